// File: rtl/seq_det_pkg.sv
// Shared types and default constants for the serial sequence detector.
package seq_det_pkg;

    typedef enum logic {
        FILL    = 1'b0,
        COMPARE = 1'b1
    } seq_det_state_t;

    localparam int unsigned DEF_PATTERN_W = 4;
    localparam logic [3:0]  DEF_PATTERN   = 4'b1011;
    localparam int unsigned DEF_CNT_W     = 8;

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module seq_det_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_seq_detector.sv
// Serial MSB-first pattern detector with registered match pulse and saturating match count.
// Build option: define SEQ_DET_OVERLAP_EN for overlapping detection (default is non-overlapping).
module serial_seq_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned           PATTERN_W = DEF_PATTERN_W,
    parameter logic [PATTERN_W-1:0]  PATTERN   = PATTERN_W'(DEF_PATTERN),
    parameter int unsigned           CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             din,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy
);

    localparam int unsigned      FILL_W = $clog2(PATTERN_W);
    localparam logic [FILL_W-1:0] FULL  = FILL_W'(PATTERN_W - 1);

    seq_det_state_t       state, state_nx;
    logic [PATTERN_W-1:0] hist, hist_nx, window;
    logic [FILL_W-1:0]    fill_cnt, fill_nx;
    logic                 primed, hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            hist     <= '0;
            fill_cnt <= '0;
            match    <= 1'b0;
        end else begin
            state    <= state_nx;
            hist     <= hist_nx;
            fill_cnt <= fill_nx;
            match    <= hit;
        end
    end

    always_comb begin
        window   = {hist[PATTERN_W-2:0], din};
        primed   = (fill_cnt == FULL);
        hit      = din_valid && primed && (window == PATTERN);
        state_nx = state;
        hist_nx  = hist;
        fill_nx  = fill_cnt;
        if (din_valid) begin
            hist_nx = window;
            if (!primed) begin
                fill_nx = fill_cnt + 1'b1;
            end
            case (state)
                FILL:    if (primed) state_nx = COMPARE;
                COMPARE: state_nx = COMPARE;
                default: state_nx = FILL;
            endcase
`ifdef SEQ_DET_OVERLAP_EN
`else
            // Non-overlapping: a match discards the window, history still shifts.
            if (hit) begin
                fill_nx  = '0;
                state_nx = FILL;
            end
`endif
        end
    end

    always_comb begin
        busy = (state == COMPARE);
    end

    seq_det_sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit),
        .cnt (match_cnt)
    );

endmodule

// File: tb/tb_serial_seq_detector.sv
// Table-driven bench with scoreboard queue for serial_seq_detector (default and CNT_W=2 instances).
module tb_serial_seq_detector;

    typedef struct {
        bit rst;
        bit valid;
        bit din;
        bit m_ov;
        bit m_nov;
    } vec_t;

    typedef struct {
        bit       m;
        int       cnt;
        int       cnt2;
        bit       busy;
        bit       hist_zero;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, din_valid, din;
    logic       match, match2, busy, busy2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;

    int   errors = 0;
    int   checks = 0;
    vec_t vec[$];
    exp_t sb[$];

    // Reference model state
    int   m_hist, m_fill, m_cnt, m_cnt2;
    bit   m_busy;

    always #5 clk = ~clk;

    serial_seq_detector dut (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din       (din),
        .match     (match),
        .match_cnt (match_cnt),
        .busy      (busy)
    );

    serial_seq_detector #(
        .CNT_W (2)
    ) dut2 (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din       (din),
        .match     (match2),
        .match_cnt (match_cnt2),
        .busy      (busy2)
    );

    function automatic void add(bit r, bit v, bit d, bit mo, bit mn);
        vec_t e;
        e.rst = r; e.valid = v; e.din = d; e.m_ov = mo; e.m_nov = mn;
        vec.push_back(e);
    endfunction

    function automatic void check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endfunction

    function automatic exp_t model_step(vec_t e, bit ovl);
        exp_t x;
        int   win;
        bit   hit;
        hit = 1'b0;
        if (e.rst) begin
            m_hist = 0; m_fill = 0; m_cnt = 0; m_cnt2 = 0; m_busy = 1'b0;
        end else if (e.valid) begin
            win = ((m_hist << 1) | int'(e.din)) & 4'hF;
            hit = (m_fill >= 3) && (win == 4'b1011);
            m_hist = win;
            if (m_fill >= 3) m_busy = 1'b1;
            if (m_fill < 3) m_fill++;
            if (hit && !ovl) begin
                m_fill = 0; m_busy = 1'b0;
            end
            if (hit && m_cnt < 255) m_cnt++;
            if (hit && m_cnt2 < 3) m_cnt2++;
        end
        x.m = ovl ? e.m_ov : e.m_nov;
        x.cnt = m_cnt; x.cnt2 = m_cnt2; x.busy = m_busy;
        x.hist_zero = (m_hist == 0);
        return x;
    endfunction

    initial begin
        bit   ovl;
        exp_t x;
`ifdef SEQ_DET_OVERLAP_EN
        ovl = 1'b1;
`else
        ovl = 1'b0;
`endif
        rst = 1'b1; din_valid = 1'b0; din = 1'b0;

        // Stream 1,0,1,1,0,1,1: overlap matches after bits 4 and 7, else only bit 4
        add(1,0,0, 0,0);
        add(0,1,1, 0,0); add(0,1,0, 0,0); add(0,1,1, 0,0); add(0,1,1, 1,1);
        add(0,1,0, 0,0); add(0,1,1, 0,0); add(0,1,1, 1,0);
        add(0,0,1, 0,0);
        // Gap of three invalid cycles between bits 2 and 3
        add(1,0,0, 0,0);
        add(0,1,1, 0,0); add(0,1,0, 0,0);
        add(0,0,1, 0,0); add(0,0,1, 0,0); add(0,0,0, 0,0);
        add(0,1,1, 0,0); add(0,1,1, 1,1); add(0,0,0, 0,0);
        // Partial 1,0,1 aborted by reset that coincides with a valid 1
        add(1,0,0, 0,0);
        add(0,1,1, 0,0); add(0,1,0, 0,0); add(0,1,1, 0,0);
        add(1,1,1, 0,0);
        add(0,1,1, 0,0); add(0,1,0, 0,0); add(0,1,1, 0,0); add(0,1,1, 1,1);
        // 16-bit stream: 5 overlapping matches, 3 non-overlapping; CNT_W=2 saturates
        add(1,0,0, 0,0);
        add(0,1,1, 0,0); add(0,1,0, 0,0); add(0,1,1, 0,0); add(0,1,1, 1,1);
        add(0,1,0, 0,0); add(0,1,1, 0,0); add(0,1,1, 1,0); add(0,1,0, 0,0);
        add(0,1,1, 0,0); add(0,1,1, 1,1); add(0,1,0, 0,0); add(0,1,1, 0,0);
        add(0,1,1, 1,0); add(0,1,0, 0,0); add(0,1,1, 0,0); add(0,1,1, 1,1);
        add(0,0,0, 0,0);

        for (int unsigned i = 0; i < vec.size(); i++) begin
            @(negedge clk);
            rst = vec[i].rst; din_valid = vec[i].valid; din = vec[i].din;
            sb.push_back(model_step(vec[i], ovl));
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                check("scoreboard_empty", 1, 0);
            end else begin
                x = sb.pop_front();
                check($sformatf("match[%0d]", i),  int'(match),      int'(x.m));
                check($sformatf("match2[%0d]", i), int'(match2),     int'(x.m));
                check($sformatf("cnt[%0d]", i),    int'(match_cnt),  x.cnt);
                check($sformatf("cnt2[%0d]", i),   int'(match_cnt2), x.cnt2);
                check($sformatf("busy[%0d]", i),   int'(busy),       int'(x.busy));
                if (vec[i].rst) begin
                    check($sformatf("rst_hist[%0d]", i), int'(dut.hist == '0), int'(x.hist_zero));
                    check($sformatf("rst_fill[%0d]", i), int'(dut.fill_cnt), 0);
                end
            end
        end

        // Final hand checks on the saturation run
        check("final_cnt",  int'(match_cnt),  ovl ? 5 : 3);
        check("final_cnt2", int'(match_cnt2), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
